instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: DATA_W, 16, width of address, instruction and immediate words.
REQ-002 Parameter: IMM_BIT, 15, opcode bit that, when set, marks a two-word instruction.
REQ-003 The clock SHALL be `clk` and the reset SHALL be `r`: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 r  in  1  synchronous active-high reset.
REQ-006 pc_in  in  DATA_W  current program-counter value.
REQ-007 pc_oe  out  1  request that the program counter drive pc_in.
REQ-008 pc_e  out  1  one-cycle program-counter increment strobe.
REQ-009 mem_req  out  1  memory read request.
REQ-010 mem_addr  out  DATA_W  read address, equal to pc_in whenever mem_req=1.
REQ-011 mem_ack  in  1  memory read-data-valid strobe.
REQ-012 mem_data  in  DATA_W  memory read data, valid only when mem_ack=1.
REQ-013 flush  in  1  branch or redirect; the program counter is reloaded elsewhere in the same cycle.
REQ-014 ir_out  out  DATA_W  latched instruction word.
REQ-015 imm_out  out  DATA_W  latched immediate word, 0 for single-word instructions.
REQ-016 ir_valid  out  1  ir_out and imm_out are valid.
REQ-017 ir_ready  in  1  the decoder accepts the instruction.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH_OP, FETCH_IMM and HOLD.
REQ-019 IDLE: all outputs 0; the FSM SHALL unconditionally move to FETCH_OP on the next edge.
REQ-020 FETCH_OP and FETCH_IMM: mem_req=1 and pc_oe=1; mem_addr=pc_in; mem_req held until mem_ack.
REQ-021 FETCH_OP on mem_ack (no flush): ir_out<=mem_data; imm_out<=0; pc_e=1 combinationally in the ack cycle; next state FETCH_IMM if mem_data[IMM_BIT]=1, else HOLD.
REQ-022 FETCH_IMM on mem_ack (no flush): imm_out<=mem_data; pc_e=1 in the ack cycle; next state HOLD.
REQ-023 HOLD: ir_valid=1, mem_req=0, pc_e=0; ir_out and imm_out SHALL stay stable until accepted.
REQ-024 HOLD with ir_ready=1 (no flush): next state FETCH_OP, so ir_valid is 0 on the following cycle.
REQ-025 Latency: with a zero-wait memory (ack in the request cycle), a single-word instruction is valid 1 cycle after FETCH_OP is entered and a two-word instruction 2 cycles after; sustained throughput is one single-word instruction per 2 cycles.
REQ-026 A wait-state memory SHALL stretch FETCH_OP or FETCH_IMM indefinitely with no timeout.
REQ-027 pc_e SHALL never be asserted outside an acknowledged fetch cycle, and never more than once per fetched word.
REQ-028 flush in any state other than IDLE: next state FETCH_OP; ir_valid=0 next cycle; pc_e=0 in the flush cycle; any concurrent mem_ack and its data are discarded.
REQ-029 flush in IDLE SHALL have no additional effect.
REQ-030 flush together with ir_ready in HOLD: flush SHALL win and the instruction counts as dropped.
REQ-031 The block SHALL not track address wrap-around; 0xFFFF to 0x0000 is handled by the program counter, and a two-word instruction at 0xFFFF fetches its immediate from 0x0000.

Reset
REQ-032 With r=1 at a clock edge, the next state SHALL be IDLE; ir_out and imm_out SHALL be 0; ir_valid, mem_req, pc_oe and pc_e SHALL be 0 from the following cycle.
REQ-033 Reset SHALL take priority over flush, mem_ack and ir_ready.
REQ-034 Reset asserted mid-fetch SHALL drop the request; a late mem_ack received in IDLE SHALL be ignored.

Structure
REQ-035 A shared package cpu_pkg SHALL hold the fetch-state enum typedef, the DATA_W default and the IMM_BIT default.
REQ-036 The block SHALL be a single module: one FSM plus two data registers; no sub-module is warranted.

Verification
REQ-037 Reset, then zero-wait memory returns 0x1234 at pc 0x0000 with ir_ready=1: mem_req in cycle 1; pc_e pulses once; ir_valid=1 with ir_out=0x1234 and imm_out=0 in cycle 2.
REQ-038 Two-word instruction: words 0x8001 then 0xBEEF: ir_out=0x8001, imm_out=0xBEEF, exactly two pc_e pulses, ir_valid raised once.
REQ-039 Back-pressure: ir_ready=0 for 5 cycles in HOLD: ir_valid stays 1, outputs stable, no mem_req and no pc_e; ready then gives exactly one accept.
REQ-040 Wait states: mem_ack delayed 3 cycles: mem_req and mem_addr held constant for 4 cycles; pc_e appears only in the ack cycle.
REQ-041 flush coincident with mem_ack in FETCH_IMM: no pc_e, ir_valid stays 0, and the next fetch is issued from the reloaded pc_in.
REQ-042 r asserted in FETCH_OP while mem_ack=1: no pc_e; all outputs are 0 next cycle; fetching restarts via IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-state encoding and default word geometry.
package cpu_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int IMM_BIT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FETCH_OP  = 2'd1,
      ST_FETCH_IMM = 2'd2,
      ST_HOLD      = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads one- or two-word instructions at pc_in and holds them until the decoder accepts.
// Valid 1 cycle after FETCH_OP with a zero-wait memory (2 for two-word); ir_ready low holds HOLD indefinitely.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int IMM_BIT = IMM_BIT_DEF
) (
   input  logic              clk,
   input  logic              r,
   input  logic [DATA_W-1:0] pc_in,
   output logic              pc_oe,
   output logic              pc_e,
   output logic              mem_req,
   output logic [DATA_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              flush,
   output logic [DATA_W-1:0] ir_out,
   output logic [DATA_W-1:0] imm_out,
   output logic              ir_valid,
   input  logic              ir_ready
);

   fetch_state_t state, state_nxt;
   logic         ld_ir;
   logic         ld_imm;

   always_ff @(posedge clk) begin
      if (r) begin
         state   <= ST_IDLE;
         ir_out  <= '0;
         imm_out <= '0;
      end else begin
         state <= state_nxt;
         if (ld_ir) begin
            ir_out  <= mem_data;
            imm_out <= '0;
         end
         if (ld_imm) begin
            imm_out <= mem_data;
         end
      end
   end

   // A word is consumed only when acked without a concurrent flush or reset.
   always_comb begin
      state_nxt = state;
      pc_oe     = 1'b0;
      pc_e      = 1'b0;
      mem_req   = 1'b0;
      mem_addr  = '0;
      ir_valid  = 1'b0;
      ld_ir     = 1'b0;
      ld_imm    = 1'b0;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_FETCH_OP;
         end
         ST_FETCH_OP: begin
            mem_req  = 1'b1;
            pc_oe    = 1'b1;
            mem_addr = pc_in;
            if (flush) begin
               state_nxt = ST_FETCH_OP;
            end else if (mem_ack) begin
               pc_e      = ~r;
               ld_ir     = 1'b1;
               state_nxt = mem_data[IMM_BIT] ? ST_FETCH_IMM : ST_HOLD;
            end
         end
         ST_FETCH_IMM: begin
            mem_req  = 1'b1;
            pc_oe    = 1'b1;
            mem_addr = pc_in;
            if (flush) begin
               state_nxt = ST_FETCH_OP;
            end else if (mem_ack) begin
               pc_e      = ~r;
               ld_imm    = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            ir_valid = 1'b1;
            if (flush || ir_ready) begin
               state_nxt = ST_FETCH_OP;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural program counter.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        r = 1'b1;
   logic [15:0] pc_in;
   logic        pc_oe;
   logic        pc_e;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_data = '0;
   logic        flush = 1'b0;
   logic [15:0] ir_out;
   logic [15:0] imm_out;
   logic        ir_valid;
   logic        ir_ready = 1'b0;

   logic [15:0] reload = '0;
   int          vectors = 0;
   int          miscompares = 0;

   instruction_fetch #(.DATA_W(16), .IMM_BIT(15)) dut (
      .clk(clk), .r(r), .pc_in(pc_in), .pc_oe(pc_oe), .pc_e(pc_e),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_data(mem_data), .flush(flush), .ir_out(ir_out),
      .imm_out(imm_out), .ir_valid(ir_valid), .ir_ready(ir_ready)
   );

   always #5 clk = ~clk;

   // Program counter model: reset to 0, reload on flush, step on pc_e.
   always @(posedge clk) begin
      if (r) pc_in <= 16'h0000;
      else if (flush) pc_in <= reload;
      else if (pc_e) pc_in <= pc_in + 16'h0001;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [5:0] outs;
      r = 1'b1; flush = 1'b1; mem_ack = 1'b1; ir_ready = 1'b1;
      tick(); tick();
      flush = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0; #1;
      outs = {ir_valid, mem_req, pc_oe, pc_e, |ir_out, |imm_out};
      vectors++; if (outs !== 6'b0) begin miscompares++; $display("FAIL reset_outs: got %b want 000000", outs); end
      r = 1'b0; #1;
      outs = {ir_valid, mem_req, pc_oe, pc_e, |ir_out, |imm_out};
      vectors++; if (outs !== 6'b0) begin miscompares++; $display("FAIL idle_outs: got %b want 000000", outs); end
      vectors++; if (mem_addr !== 16'h0) begin miscompares++; $display("FAIL idle_addr: got %h want 0000", mem_addr); end
   endtask

   task automatic test_single_word();
      tick();
      mem_ack = 1'b1; mem_data = 16'h1234; ir_ready = 1'b1; #1;
      vectors++; if ({mem_req, pc_oe} !== 2'b11) begin miscompares++; $display("FAIL single_req: got %b want 11", {mem_req, pc_oe}); end
      vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL single_addr: got %h want 0000", mem_addr); end
      vectors++; if (pc_e !== 1'b1) begin miscompares++; $display("FAIL single_pce: got %b want 1", pc_e); end
      tick();
      mem_ack = 1'b0; #1;
      vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", ir_valid); end
      vectors++; if (ir_out !== 16'h1234) begin miscompares++; $display("FAIL single_ir: got %h want 1234", ir_out); end
      vectors++; if (imm_out !== 16'h0000) begin miscompares++; $display("FAIL single_imm: got %h want 0000", imm_out); end
      vectors++; if ({mem_req, pc_e} !== 2'b00) begin miscompares++; $display("FAIL single_hold_quiet: got %b want 00", {mem_req, pc_e}); end
      tick();
      ir_ready = 1'b0; #1;
      vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL single_accept: got %b want 0", ir_valid); end
   endtask

   task automatic test_two_word();
      int pulses = 0;
      mem_ack = 1'b1; mem_data = 16'h8001; #1;
      if (pc_e) pulses++;
      vectors++; if (mem_addr !== 16'h0001) begin miscompares++; $display("FAIL two_op_addr: got %h want 0001", mem_addr); end
      tick();
      mem_data = 16'hBEEF; #1;
      if (pc_e) pulses++;
      vectors++; if ({mem_req, ir_valid} !== 2'b10) begin miscompares++; $display("FAIL two_imm_state: got %b want 10", {mem_req, ir_valid}); end
      vectors++; if (mem_addr !== 16'h0002) begin miscompares++; $display("FAIL two_imm_addr: got %h want 0002", mem_addr); end
      tick();
      mem_ack = 1'b0; #1;
      if (pc_e) pulses++;
      vectors++; if (pulses !== 2) begin miscompares++; $display("FAIL two_pce_count: got %0d want 2", pulses); end
      vectors++; if ({ir_valid, ir_out, imm_out} !== {1'b1, 16'h8001, 16'hBEEF}) begin miscompares++; $display("FAIL two_result: got %b %h %h want 1 8001 beef", ir_valid, ir_out, imm_out); end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (ir_valid !== 1'b1 || ir_out !== 16'h8001 || imm_out !== 16'hBEEF || mem_req !== 1'b0 || pc_e !== 1'b0) bad++;
         tick();
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
      vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL bp_still_valid: got %b want 1", ir_valid); end
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0; #1;
      vectors++; if ({ir_valid, mem_req} !== 2'b01) begin miscompares++; $display("FAIL bp_accept: got %b want 01", {ir_valid, mem_req}); end
      tick();
      vectors++; if ({ir_valid, mem_req, pc_e} !== 3'b010) begin miscompares++; $display("FAIL bp_single_accept: got %b want 010", {ir_valid, mem_req, pc_e}); end
   endtask

   task automatic test_wait_states();
      int bad = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (mem_req !== 1'b1 || mem_addr !== 16'h0003 || pc_e !== 1'b0) bad++;
         tick();
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL wait_held: got %0d bad cycles want 0", bad); end
      mem_ack = 1'b1; mem_data = 16'h0042; #1;
      vectors++; if ({mem_req, pc_e, mem_addr} !== {2'b11, 16'h0003}) begin miscompares++; $display("FAIL wait_ack: got %b %h want 11 0003", {mem_req, pc_e}, mem_addr); end
      tick();
      mem_ack = 1'b0; ir_ready = 1'b1; #1;
      vectors++; if ({ir_valid, ir_out} !== {1'b1, 16'h0042}) begin miscompares++; $display("FAIL wait_result: got %b %h want 1 0042", ir_valid, ir_out); end
      tick();
      ir_ready = 1'b0;
   endtask

   task automatic test_flush_imm();
      mem_ack = 1'b1; mem_data = 16'h9000;
      tick();
      mem_data = 16'hDEAD; flush = 1'b1; reload = 16'h0100; #1;
      vectors++; if ({mem_req, pc_e} !== 2'b10) begin miscompares++; $display("FAIL flush_pce: got %b want 10", {mem_req, pc_e}); end
      tick();
      flush = 1'b0; mem_ack = 1'b0; #1;
      vectors++; if ({ir_valid, mem_req, mem_addr} !== {2'b01, 16'h0100}) begin miscompares++; $display("FAIL flush_refetch: got %b %h want 01 0100", {ir_valid, mem_req}, mem_addr); end
   endtask

   task automatic test_wrap();
      flush = 1'b1; reload = 16'hFFFF;
      tick();
      flush = 1'b0; mem_ack = 1'b1; mem_data = 16'h8123; #1;
      vectors++; if ({pc_e, mem_addr} !== {1'b1, 16'hFFFF}) begin miscompares++; $display("FAIL wrap_op: got %b %h want 1 ffff", pc_e, mem_addr); end
      tick();
      mem_data = 16'h5555; #1;
      vectors++; if ({pc_e, mem_addr} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL wrap_imm: got %b %h want 1 0000", pc_e, mem_addr); end
      tick();
      mem_ack = 1'b0; ir_ready = 1'b1; #1;
      vectors++; if ({ir_out, imm_out} !== {16'h8123, 16'h5555}) begin miscompares++; $display("FAIL wrap_result: got %h %h want 8123 5555", ir_out, imm_out); end
      tick();
      ir_ready = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      logic [5:0] outs;
      mem_ack = 1'b1; mem_data = 16'h7777; r = 1'b1; #1;
      vectors++; if (pc_e !== 1'b0) begin miscompares++; $display("FAIL rmid_pce: got %b want 0", pc_e); end
      tick();
      r = 1'b0; #1;
      outs = {ir_valid, mem_req, pc_oe, pc_e, |ir_out, |imm_out};
      vectors++; if ({outs, mem_addr} !== 22'b0) begin miscompares++; $display("FAIL rmid_outs: got %b %h want 000000 0000", outs, mem_addr); end
      tick();
      mem_ack = 1'b0; #1;
      vectors++; if ({ir_valid, mem_req, pc_e, mem_addr} !== {3'b010, 16'h0000}) begin miscompares++; $display("FAIL rmid_restart: got %b %h want 010 0000", {ir_valid, mem_req, pc_e}, mem_addr); end
   endtask

   task automatic test_flush_vs_ready();
      mem_ack = 1'b1; mem_data = 16'h0011;
      tick();
      mem_ack = 1'b0; flush = 1'b1; ir_ready = 1'b1; reload = 16'h0200; #1;
      vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL fr_hold: got %b want 1", ir_valid); end
      tick();
      flush = 1'b0; ir_ready = 1'b0; #1;
      vectors++; if ({ir_valid, mem_req, mem_addr} !== {2'b01, 16'h0200}) begin miscompares++; $display("FAIL fr_flush_wins: got %b %h want 01 0200", {ir_valid, mem_req}, mem_addr); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_two_word();
      test_backpressure();
      test_wait_states();
      test_flush_imm();
      test_wrap();
      test_reset_mid_fetch();
      test_flush_vs_ready();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
